// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC, one-cycle fetch register,
// redirect/flush handling and a sticky fault on misaligned targets.
module inst_fetch #(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DEPTH-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [DEPTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_inst,
    output logic [DEPTH-1:0] out_pc,
    output logic             fault,
    output logic [31:0]      fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] pc;
    logic             accept;

    assign imem_addr = pc;
    assign imem_rd   = (state == RUN);
    assign accept    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= DEPTH'(RESET_PC);
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            // The flush cycle of a redirect still counts a handshake
            if (accept)
                fetch_count <= fetch_count + 32'd1;
            unique case (state)
                IDLE: begin
                    state <= RUN;
                    if (accept)
                        out_valid <= 1'b0;
                end
                RUN: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        if (redirect_pc[1:0] != 2'b00) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (!out_valid || out_ready) begin
                        out_inst  <= imem_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + DEPTH'(4);
                    end
                end
                FAULT: begin
                    if (accept)
                        out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch against a fetch-rule model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [15:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    inst_fetch dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    assign imem_data = mem[imem_addr[15:2]];

    typedef struct packed {
        logic [31:0] inst;
        logic [15:0] pc;
    } fetch_t;

    fetch_t q[$];

    int checks = 0;
    int failures = 0;
    bit active = 0;

    // Model state: started = first clock after reset seen, faulted = stuck
    bit          m_started;
    bit          m_faulted;
    bit          m_valid;
    logic [15:0] m_pc;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_faulted = 0;
        m_valid   = 0;
        m_pc      = 16'h0000;
        m_count   = 0;
        q.delete();
    endtask

    task automatic model_edge();
        if (m_valid && out_ready)
            m_count = m_count + 1;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_faulted) begin
            if (redirect_valid) begin
                m_valid = 0;
                if (redirect_pc % 4 != 0)
                    m_faulted = 1;
                else
                    m_pc = redirect_pc;
            end else if (!m_valid || out_ready) begin
                q.push_back('{inst: mem[m_pc / 4], pc: m_pc});
                m_valid = 1;
                m_pc = m_pc + 16'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] p);
        out_ready = r;
        redirect_valid = v;
        redirect_pc = p;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(fetch_count), 64'd0);
        chk("async_rst_fault", 64'(fault), 64'd0);
        chk("async_rst_addr", 64'(imem_addr), 64'h0);
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (active && !rst) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("fault", 64'(fault), 64'(m_faulted));
            chk("imem_rd", 64'(imem_rd), 64'(m_started && !m_faulted));
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            chk("fetch_count", 64'(fetch_count), 64'(m_count));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got pc %0h expected none", out_pc);
                end else begin
                    chk("out_inst", 64'(out_inst), 64'(q[0].inst));
                    chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                    if (out_ready || redirect_valid)
                        void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        model_reset();
        #1;
        chk("reset_inst", 64'(out_inst), 64'd0);
        chk("reset_pc", 64'(out_pc), 64'd0);
        chk("reset_rd", 64'(imem_rd), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        active = 1;

        // Sequential fetch, stall at pc 4, redirect while stalled
        repeat (3) step(1'b1, 1'b0, 16'h0);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0040);
        repeat (3) step(1'b1, 1'b0, 16'h0);

        // Address wrap at the top of the space
        step(1'b1, 1'b1, 16'hFFF8);
        repeat (5) step(1'b1, 1'b0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic v;
            logic [15:0] p;
            r = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 7) == 0);
            p = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 7) == 0)
                p = 16'hFFF0 | (p & 16'h000C);
            step(r, v, p);
        end

        async_reset_check();
        repeat (4) step(1'b1, 1'b0, 16'h0);

        // Misaligned redirect then attempts to escape the fault
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0042);
        repeat (3) step(1'b1, 1'b1, 16'h0080);
        repeat (3) step(1'b1, 1'b0, 16'h0);

        async_reset_check();
        repeat (6) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0003);
        repeat (2) step(1'b1, 1'b0, 16'h0);

        active = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction/data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning byte-address width of instruction memory.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_addr  output  DEPTH  byte address presented to instruction memory.
REQ-007 SHALL have port imem_rd  output  1  read enable to instruction memory.
REQ-008 SHALL have port imem_data  input  WIDTH  little-endian word returned combinationally for imem_addr.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 SHALL have port redirect_pc  input  DEPTH  target byte address of the redirect.
REQ-011 SHALL have port out_valid  output  1  out_inst/out_pc hold a valid fetched instruction.
REQ-012 SHALL have port out_ready  input  1  decode stage accepts the current instruction.
REQ-013 SHALL have port out_inst  output  WIDTH  registered instruction word.
REQ-014 SHALL have port out_pc  output  DEPTH  byte address of out_inst.
REQ-015 SHALL have port fault  output  1  misaligned redirect detected; fetch stopped.
REQ-016 SHALL have port fetch_count  output  32  number of accepted instructions.

Function
REQ-017 SHALL implement three states: IDLE, RUN, FAULT; IDLE -> RUN unconditionally on the first clock after reset release.
REQ-018 SHALL drive imem_addr = pc at all times and imem_rd = 1 only in RUN.
REQ-019 SHALL define "advance" = RUN and (out_valid == 0 or out_ready == 1) and redirect_valid == 0.
REQ-020 On advance: out_inst <= imem_data, out_pc <= pc, out_valid <= 1, pc <= pc + 4; latency from pc presented to out_inst valid is exactly 1 cycle.
REQ-021 When out_valid == 1 and out_ready == 0 with no redirect (stall): pc, out_inst, out_pc, out_valid SHALL hold unchanged.
REQ-022 When out_valid == 1, out_ready == 1 and not advancing (IDLE/FAULT): out_valid <= 0.
REQ-023 PC increment SHALL wrap modulo 2^DEPTH (pc 0xFFFC -> 0x0000 for DEPTH=16) with no fault.
REQ-024 On redirect_valid == 1 in RUN with redirect_pc[1:0] == 0: pc <= redirect_pc, out_valid <= 0 (flush), no fetch that cycle; redirect overrides stall and any pending advance.
REQ-025 On redirect_valid == 1 in RUN with redirect_pc[1:0] != 0: state <= FAULT, out_valid <= 0, pc holds, fault <= 1.
REQ-026 FAULT SHALL be sticky until reset; redirect_valid and out_ready SHALL be ignored in FAULT and IDLE.
REQ-027 fetch_count SHALL increment by 1 on every cycle with out_valid == 1 and out_ready == 1, including the flush cycle of a redirect, and SHALL wrap at 2^32.
REQ-028 pc[1:0] SHALL always be 0 in RUN.

Reset
REQ-029 On rst assertion, asynchronously: state = IDLE, pc = RESET_PC, out_valid = 0, out_inst = 0, out_pc = 0, fault = 0, fetch_count = 0, imem_rd = 0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending instruction and redirect; fetch restarts at RESET_PC.

Verification
REQ-031 Reset release, out_ready = 1, mem words 0x11,0x22,0x33 at 0,4,8 -> out_inst 0x11/0x22/0x33 with out_pc 0/4/8 on cycles 2/3/4 after release; fetch_count = 3 after cycle 4.
REQ-032 out_ready = 0 for 3 cycles while out_pc = 4 -> out_inst/out_pc/pc unchanged, fetch_count unchanged; on out_ready = 1 next out_pc = 8.
REQ-033 redirect_valid = 1, redirect_pc = 0x0040 while stalled -> next cycle out_valid = 0, imem_addr = 0x0040; following cycle out_pc = 0x0040.
REQ-034 redirect_pc = 0x0042 -> fault = 1, out_valid = 0, imem_rd = 0 next cycle; stays set despite further redirects until rst.
REQ-035 redirect to 0xFFF8, out_ready = 1 -> out_pc 0xFFF8, 0xFFFC, 0x0000, fault = 0.
REQ-036 rst pulsed asynchronously (between clock edges) while out_valid = 1 -> out_valid = 0, fetch_count = 0 immediately; first post-reset out_pc = RESET_PC.
